// File: rtl/mem_access_unit.sv
// Request sequencer in front of an 8-bit data memory. It splits byte or
// 16-bit little-endian loads and stores into one or two single-byte accesses.
module mem_access_unit #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ReqValid,
    output logic          ReqReady,
    input  logic          ReqWrite,
    input  logic          ReqWide,
    input  logic [AW-1:0] ReqAddr,
    input  logic [15:0]   ReqData,
    output logic          RespValid,
    output logic [15:0]   RespData,
    output logic [AW-1:0] DataAddress,
    output logic          ReadMem,
    output logic          WriteMem,
    output logic [7:0]    DataIn,
    input  logic [7:0]    DataOut
);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RESP} state_t;

    state_t        r_state, w_next;
    logic          r_write, r_wide;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_data;
    logic [7:0]    r_lo, r_hi;
    logic          r_resp_valid;
    logic [15:0]   r_resp_data;
    logic          w_accept;

    assign w_accept  = ReqValid && (r_state == S_IDLE);
    assign RespValid = r_resp_valid;
    assign RespData  = r_resp_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_LO;
            S_LO:   w_next = r_wide ? S_HI : (r_write ? S_IDLE : S_RESP);
            S_HI:   w_next = r_write ? S_IDLE : S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Memory-port drive depends only on state and registered request fields.
    always_comb begin
        ReqReady    = (r_state == S_IDLE);
        ReadMem     = 1'b0;
        WriteMem    = 1'b0;
        DataAddress = '0;
        DataIn      = 8'h00;
        case (r_state)
            S_LO: begin
                DataAddress = r_addr;
                WriteMem    = r_write;
                ReadMem     = !r_write;
                DataIn      = r_write ? r_data[7:0] : 8'h00;
            end
            S_HI: begin
                DataAddress = r_addr + AW'(1);
                WriteMem    = r_write;
                ReadMem     = !r_write;
                DataIn      = r_write ? r_data[15:8] : 8'h00;
            end
            default: ;
        endcase
    end

    // The response is registered on the edge that leaves RESP, so the
    // pulse lands in the first IDLE cycle and RespData holds until the next load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write      <= 1'b0;
            r_wide       <= 1'b0;
            r_addr       <= '0;
            r_data       <= 16'h0000;
            r_lo         <= 8'h00;
            r_hi         <= 8'h00;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 16'h0000;
        end else begin
            if (w_accept) begin
                r_write <= ReqWrite;
                r_wide  <= ReqWide;
                r_addr  <= ReqAddr;
                r_data  <= ReqData;
                r_lo    <= 8'h00;
                r_hi    <= 8'h00;
            end
            if (r_state == S_LO && !r_write) r_lo <= DataOut;
            if (r_state == S_HI && !r_write) r_hi <= DataOut;
            r_resp_valid <= (r_state == S_RESP);
            if (r_state == S_RESP) r_resp_data <= {r_hi, r_lo};
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural byte memory plus a flat reference
// array; directed and random loads/stores with timing and data checks.
module tb_mem_access_unit;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ReqValid, ReqReady, ReqWrite, ReqWide;
    logic [AW-1:0] ReqAddr;
    logic [15:0]   ReqData;
    logic          RespValid;
    logic [15:0]   RespData;
    logic [AW-1:0] DataAddress;
    logic          ReadMem, WriteMem;
    logic [7:0]    DataIn, DataOut;

    mem_access_unit #(.AW(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqWide(ReqWide), .ReqAddr(ReqAddr), .ReqData(ReqData),
        .RespValid(RespValid), .RespData(RespData),
        .DataAddress(DataAddress), .ReadMem(ReadMem), .WriteMem(WriteMem),
        .DataIn(DataIn), .DataOut(DataOut)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256] = '{default: 8'h00};
    always @(posedge clk) if (WriteMem) mem[DataAddress] <= DataIn;
    assign DataOut = mem[DataAddress];

    logic [7:0]  ref_mem [256];
    logic [15:0] last_resp = 16'h0000;
    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run_req(input logic w, input logic wide, input logic [7:0] a, input logic [15:0] d);
        int resp_cnt, resp_at, rdy_at, wr_cnt, rd_cnt, exp_rdy, exp_acc;
        bit both;
        logic [7:0]  a1;
        logic [15:0] exp;
        a1 = a + 8'd1;
        @(negedge clk);
        chk("ready_idle", 32'(ReqReady), 32'd1);
        ReqValid = 1'b1; ReqWrite = w; ReqWide = wide; ReqAddr = a; ReqData = d;
        @(posedge clk); #1;
        ReqValid = 1'b0;
        ReqWrite = 1'($urandom_range(0, 1)); ReqWide = 1'($urandom_range(0, 1));
        ReqAddr = 8'($urandom); ReqData = 16'($urandom);
        resp_cnt = 0; resp_at = -1; rdy_at = -1; wr_cnt = 0; rd_cnt = 0; both = 0;
        for (int c = 0; c < 6; c++) begin
            if (WriteMem) wr_cnt++;
            if (ReadMem) rd_cnt++;
            if (WriteMem && ReadMem) both = 1;
            if (RespValid) begin
                resp_cnt++;
                if (resp_at < 0) resp_at = c;
            end
            if (ReqReady && rdy_at < 0) rdy_at = c;
            @(posedge clk); #1;
        end
        exp_acc = wide ? 2 : 1;
        if (w) begin
            ref_mem[a] = d[7:0];
            if (wide) ref_mem[a1] = d[15:8];
            exp = last_resp;
            exp_rdy = wide ? 2 : 1;
        end else begin
            exp = wide ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
            exp_rdy = wide ? 3 : 2;
            chk("resp_cycle", resp_at, exp_rdy);
        end
        chk("ready_cycle", rdy_at, exp_rdy);
        chk("resp_count", resp_cnt, w ? 0 : 1);
        chk("write_count", wr_cnt, w ? exp_acc : 0);
        chk("read_count", rd_cnt, w ? 0 : exp_acc);
        chk("rd_wr_excl", 32'(both), 32'd0);
        chk("resp_data", 32'(RespData), 32'(exp));
        chk("mem_lo", 32'(mem[a]), 32'(ref_mem[a]));
        chk("mem_hi", 32'(mem[a1]), 32'(ref_mem[a1]));
        last_resp = exp;
    endtask

    initial begin
        logic [7:0] d8;
        int pulses;
        ReqValid = 1'b0; ReqWrite = 1'b0; ReqWide = 1'b0; ReqAddr = '0; ReqData = 16'h0000;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        #1;
        chk("rst_ready", 32'(ReqReady), 32'd1);
        chk("rst_resp_valid", 32'(RespValid), 32'd0);
        chk("rst_resp_data", 32'(RespData), 32'd0);
        chk("rst_read", 32'(ReadMem), 32'd0);
        chk("rst_write", 32'(WriteMem), 32'd0);
        chk("rst_addr", 32'(DataAddress), 32'd0);
        chk("rst_din", 32'(DataIn), 32'd0);
        @(negedge clk); reset_n = 1'b1;

        run_req(1'b1, 1'b0, 8'h20, 16'h00A5);
        run_req(1'b0, 1'b0, 8'h20, 16'h0000);
        run_req(1'b1, 1'b1, 8'h10, 16'hBEEF);
        run_req(1'b0, 1'b1, 8'h10, 16'h0000);
        run_req(1'b1, 1'b1, 8'hFF, 16'h1234);
        run_req(1'b0, 1'b1, 8'hFF, 16'h0000);
        chk("wrap_mem0", 32'(mem[0]), 32'h12);

        // Store then load of the same byte with ReqValid held high throughout.
        d8 = 8'($urandom);
        @(negedge clk);
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqWide = 1'b0; ReqAddr = 8'h33; ReqData = {8'h5A, d8};
        @(posedge clk); #1;
        ReqWrite = 1'b0;
        chk("b2b_busy", 32'(ReqReady), 32'd0);
        @(posedge clk); #1;
        chk("b2b_ready", 32'(ReqReady), 32'd1);
        @(posedge clk); #1;
        chk("b2b_busy2", 32'(ReqReady), 32'd0);
        ReqValid = 1'b0;
        ref_mem[8'h33] = d8;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (RespValid) pulses++;
            @(posedge clk); #1;
        end
        chk("b2b_pulses", pulses, 1);
        chk("b2b_data", 32'(RespData), 32'(d8));
        last_resp = {8'h00, d8};

        // Reset during the HI write of a wide store.
        run_req(1'b1, 1'b0, 8'h41, 16'h0000);
        @(negedge clk);
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqWide = 1'b1; ReqAddr = 8'h40; ReqData = 16'hCAFE;
        @(posedge clk); #1;
        ReqValid = 1'b0;
        @(posedge clk); #1;
        chk("hi_write", 32'(WriteMem), 32'd1);
        chk("hi_addr", 32'(DataAddress), 32'h41);
        #2 reset_n = 1'b0;
        #1 chk("rst_async_write", 32'(WriteMem), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); reset_n = 1'b1;
        #1;
        chk("rst_hi_ready", 32'(ReqReady), 32'd1);
        chk("rst_hi_rv", 32'(RespValid), 32'd0);
        chk("rst_hi_rd", 32'(RespData), 32'd0);
        chk("rst_hi_mem40", 32'(mem[8'h40]), 32'hFE);
        chk("rst_hi_mem41", 32'(mem[8'h41]), 32'h00);
        ref_mem[8'h40] = 8'hFE;
        last_resp = 16'h0000;

        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra;
            ra = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom);
            run_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
